// File: rtl/vreg_operand_reader.sv
// Snapshots the vs1/vs2 operand registers and the v0 mask, then streams them to
// the ALU as WIDTH-bit beats with per-byte enables derived from sew, vl and mask.
module vreg_operand_reader #(
    parameter int WIDTH = 32,
    parameter int VLEN  = 128
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [$clog2(WIDTH)-1:0]          i_vs1_addr,
    input  logic [$clog2(WIDTH)-1:0]          i_vs2_addr,
    input  logic [$clog2(VLEN/8):0]           i_vl,
    input  logic [1:0]                        i_sew,
    input  logic                              i_vm,
    output logic [$clog2(WIDTH)-1:0]          o_Vregs_output_addr0,
    output logic [$clog2(WIDTH)-1:0]          o_Vregs_output_addr1,
    input  logic [VLEN-1:0]                   i_vreg_data0,
    input  logic [VLEN-1:0]                   i_vreg_data1,
    input  logic [VLEN-1:0]                   i_mask,
    output logic                              o_op_valid,
    input  logic                              i_op_ready,
    output logic [WIDTH-1:0]                  o_op_a,
    output logic [WIDTH-1:0]                  o_op_b,
    output logic [WIDTH/8-1:0]                o_byte_en,
    output logic [$clog2(VLEN/WIDTH)-1:0]     o_beat,
    output logic                              o_last,
    output logic                              o_busy,
    output logic                              o_done
);
    localparam int AW  = $clog2(WIDTH);
    localparam int BPB = WIDTH / 8;
    localparam int BBW = $clog2(BPB);
    localparam int NB  = VLEN / WIDTH;
    localparam int BW  = $clog2(NB);
    localparam int CW  = $clog2(NB + 1);
    localparam int GW  = $clog2(VLEN / 8);
    localparam int VLW = GW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LATCH  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic [1:0] sat_sew(input logic [1:0] sew);
        return (sew == 2'd3) ? 2'd2 : sew;
    endfunction

    function automatic logic [VLW-1:0] clamp_vl(input logic [VLW-1:0] vl, input logic [1:0] sew);
        logic [VLW-1:0] vmax;
        vmax = VLW'((VLEN / 8) >> sew);
        return (vl > vmax) ? vmax : vl;
    endfunction

    // Active bytes rounded up to whole beats.
    function automatic logic [CW-1:0] beat_count(input logic [VLW-1:0] vl, input logic [1:0] sew);
        logic [VLW+2:0] nbytes;
        nbytes = {3'b000, vl} << sew;
        return CW'((nbytes + (VLW+3)'(BPB - 1)) / (VLW+3)'(BPB));
    endfunction

    function automatic logic [BPB-1:0] beat_ben(input logic [BW-1:0] b, input logic [VLW-1:0] vl,
                                                input logic [1:0] sew, input logic vm,
                                                input logic [VLEN-1:0] mask);
        logic [BPB-1:0] en;
        logic [GW-1:0]  g;
        logic [GW-1:0]  e;
        en = '0;
        for (int j = 0; j < BPB; j++) begin
            g     = {b, BBW'(j)};
            e     = g >> sew;
            en[j] = ({1'b0, e} < vl) && (vm || mask[e]);
        end
        return en;
    endfunction

    logic [1:0]       state;
    logic [AW-1:0]    addr0_p0, addr1_p0;
    logic [1:0]       sew_p0;
    logic [VLW-1:0]   vl_p0;
    logic             vm_p0;
    logic [CW-1:0]    cnt_p0;
    logic [VLEN-1:0]  snap_a_p0, snap_b_p0, snap_m_p0;
    logic             vld_p1, last_p1;
    logic [BW-1:0]    beat_p1;
    logic [BPB-1:0]   ben_p1;
    logic [WIDTH-1:0] op_a_p1, op_b_p1;

    logic [1:0]       sew_in;
    logic [CW-1:0]    cnt_nxt;
    logic [BW-1:0]    nxt_beat;
    logic             load;

    assign sew_in   = sat_sew(i_sew);
    assign cnt_nxt  = beat_count(vl_p0, sew_p0);
    assign nxt_beat = vld_p1 ? beat_p1 + BW'(1) : '0;
    assign load     = !vld_p1 || i_op_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            addr0_p0  <= '0;
            addr1_p0  <= '0;
            sew_p0    <= '0;
            vl_p0     <= '0;
            vm_p0     <= 1'b0;
            cnt_p0    <= '0;
            snap_a_p0 <= '0;
            snap_b_p0 <= '0;
            snap_m_p0 <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            beat_p1   <= '0;
            ben_p1    <= '0;
            op_a_p1   <= '0;
            op_b_p1   <= '0;
        end else begin
            case (state)
                // p0: capture request, then the register-file snapshot
                S_IDLE: begin
                    if (i_start) begin
                        addr0_p0 <= i_vs1_addr;
                        addr1_p0 <= i_vs2_addr;
                        vm_p0    <= i_vm;
                        sew_p0   <= sew_in;
                        vl_p0    <= clamp_vl(i_vl, sew_in);
                        state    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    snap_a_p0 <= i_vreg_data0;
                    snap_b_p0 <= i_vreg_data1;
                    snap_m_p0 <= i_mask;
                    cnt_p0    <= cnt_nxt;
                    state     <= (cnt_nxt == '0) ? S_DONE : S_STREAM;
                end
                // p1: output beat register, refilled on each accepted transfer
                S_STREAM: begin
                    if (vld_p1 && i_op_ready && last_p1) begin
                        vld_p1  <= 1'b0;
                        last_p1 <= 1'b0;
                        beat_p1 <= '0;
                        ben_p1  <= '0;
                        state   <= S_DONE;
                    end else if (load) begin
                        vld_p1  <= 1'b1;
                        beat_p1 <= nxt_beat;
                        last_p1 <= (CW'(nxt_beat) == cnt_p0 - CW'(1));
                        ben_p1  <= beat_ben(nxt_beat, vl_p0, sew_p0, vm_p0, snap_m_p0);
                        op_a_p1 <= snap_a_p0[{nxt_beat, {AW{1'b0}}} +: WIDTH];
                        op_b_p1 <= snap_b_p0[{nxt_beat, {AW{1'b0}}} +: WIDTH];
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_Vregs_output_addr0 = addr0_p0;
    assign o_Vregs_output_addr1 = addr1_p0;
    assign o_op_valid = vld_p1;
    assign o_op_a     = op_a_p1;
    assign o_op_b     = op_b_p1;
    assign o_byte_en  = ben_p1;
    assign o_beat     = beat_p1;
    assign o_last     = last_p1;
    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);

endmodule

// File: tb/tb_vreg_operand_reader.sv
// Randomized bench for vreg_operand_reader with a register-file model and a
// beat-level reference model built from element/byte arithmetic.
module tb_vreg_operand_reader;
    logic         i_clk = 1'b0;
    logic         i_rst, i_start, i_vm, i_op_ready;
    logic [4:0]   i_vs1_addr, i_vs2_addr, o_Vregs_output_addr0, o_Vregs_output_addr1;
    logic [4:0]   i_vl;
    logic [1:0]   i_sew;
    logic [127:0] i_vreg_data0, i_vreg_data1, i_mask;
    logic         o_op_valid, o_last, o_busy, o_done;
    logic [31:0]  o_op_a, o_op_b;
    logic [3:0]   o_byte_en;
    logic [1:0]   o_beat;

    logic [127:0] rf [32];
    logic [70:0]  cur_pkt;
    logic [70:0]  exp_pkt [4];
    logic [70:0]  obs_pkt [8];
    int exp_cnt, n_xfer, done_k, first_valid_k, hold_viol;
    bit busy_k1, aborted;
    int errs, checks;

    always #5 i_clk = ~i_clk;

    assign i_vreg_data0 = rf[o_Vregs_output_addr0];
    assign i_vreg_data1 = rf[o_Vregs_output_addr1];
    assign i_mask       = rf[0];
    assign cur_pkt      = {o_op_a, o_op_b, o_byte_en, o_beat, o_last};

    vreg_operand_reader #(.WIDTH(32), .VLEN(128)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_vs1_addr(i_vs1_addr), .i_vs2_addr(i_vs2_addr),
        .i_vl(i_vl), .i_sew(i_sew), .i_vm(i_vm),
        .o_Vregs_output_addr0(o_Vregs_output_addr0),
        .o_Vregs_output_addr1(o_Vregs_output_addr1),
        .i_vreg_data0(i_vreg_data0), .i_vreg_data1(i_vreg_data1), .i_mask(i_mask),
        .o_op_valid(o_op_valid), .i_op_ready(i_op_ready),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_byte_en(o_byte_en),
        .o_beat(o_beat), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    // Reference: elements of (1<<sew) bytes, vl clamped to what fits in VLEN.
    function automatic void build_expect(int vs1, int vs2, int vl, int sew, int vm);
        int esz, vle, nbytes;
        logic [127:0] a, b, m;
        a = rf[vs1]; b = rf[vs2]; m = rf[0];
        if (sew > 2) sew = 2;
        esz = 1 << sew;
        vle = (vl > 16 / esz) ? 16 / esz : vl;
        nbytes = vle * esz;
        exp_cnt = (nbytes + 3) / 4;
        for (int bt = 0; bt < 4; bt++) begin
            logic [3:0] en;
            en = 4'h0;
            for (int j = 0; j < 4; j++) begin
                int el;
                el = (bt * 4 + j) / esz;
                if (el < vle && (vm != 0 || m[el])) en[j] = 1'b1;
            end
            exp_pkt[bt] = {a[bt*32 +: 32], b[bt*32 +: 32], en, 2'(bt), 1'(bt == exp_cnt - 1)};
        end
    endfunction

    task automatic start_seq(input int vs1, input int vs2, input int vl, input int sew, input int vm);
        @(negedge i_clk);
        i_vs1_addr = 5'(vs1); i_vs2_addr = 5'(vs2);
        i_vl = 5'(vl); i_sew = 2'(sew); i_vm = 1'(vm);
        i_start = 1'b1;
    endtask

    // mode 0: ready=1, 1: toggling, 2: random. Records accepted beats.
    task automatic collect(input int mode, input int abort_beat, input int ovr_reg, input bit poke);
        logic [70:0] prev_pkt;
        bit prev_stall;
        n_xfer = 0; done_k = -1; first_valid_k = -1; hold_viol = 0;
        busy_k1 = 1'b0; aborted = 1'b0; prev_stall = 1'b0; prev_pkt = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge i_clk);
            i_start = (poke && k == 3);
            if (poke && k == 3) i_vs1_addr = ~i_vs1_addr;
            case (mode)
                0:       i_op_ready = 1'b1;
                1:       i_op_ready = 1'(k % 2);
                default: i_op_ready = 1'($urandom_range(0, 1));
            endcase
            if (k == 1) busy_k1 = o_busy;
            if (o_done) begin done_k = k; break; end
            if (o_op_valid) begin
                if (first_valid_k < 0) first_valid_k = k;
                if (prev_stall && cur_pkt !== prev_pkt) hold_viol++;
                if (abort_beat >= 0 && int'(o_beat) == abort_beat) begin
                    i_rst = 1'b1; aborted = 1'b1; break;
                end
                if (ovr_reg >= 0 && o_beat == 2'd1) rf[ovr_reg] = ~rf[ovr_reg];
                if (i_op_ready) begin
                    if (n_xfer < 8) obs_pkt[n_xfer] = cur_pkt;
                    n_xfer++;
                end
            end
            prev_stall = o_op_valid && !i_op_ready;
            prev_pkt = cur_pkt;
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (o_op_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b want=0", o_op_valid); end
        checks++; if (o_last !== 1'b0) begin errs++; $display("FAIL rst_last got=%b want=0", o_last); end
        checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b want=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b want=0", o_done); end
        checks++; if (o_beat !== 2'd0) begin errs++; $display("FAIL rst_beat got=%0d want=0", o_beat); end
        checks++; if (o_byte_en !== 4'h0) begin errs++; $display("FAIL rst_ben got=%h want=0", o_byte_en); end
        checks++; if (o_Vregs_output_addr0 !== 5'd0 || o_Vregs_output_addr1 !== 5'd0) begin
            errs++; $display("FAIL rst_addr got=%0d/%0d want=0/0", o_Vregs_output_addr0, o_Vregs_output_addr1);
        end
        checks++; if (o_op_a !== 32'd0 || o_op_b !== 32'd0) begin
            errs++; $display("FAIL rst_data got=%h/%h want=0/0", o_op_a, o_op_b);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_full_unmasked;
        build_expect(3, 7, 16, 0, 1);
        start_seq(3, 7, 16, 0, 1);
        collect(0, -1, -1, 1'b1);
        checks++; if (busy_k1 !== 1'b1) begin errs++; $display("FAIL full_busy_rise got=%b want=1", busy_k1); end
        checks++; if (first_valid_k != 3) begin errs++; $display("FAIL full_first_valid got=%0d want=3", first_valid_k); end
        checks++; if (done_k != 7) begin errs++; $display("FAIL full_done_cycle got=%0d want=7", done_k); end
        checks++; if (n_xfer != 4) begin errs++; $display("FAIL full_xfers got=%0d want=4", n_xfer); end
        for (int i = 0; i < 4 && i < n_xfer; i++) begin
            checks++;
            if (obs_pkt[i] !== exp_pkt[i]) begin errs++; $display("FAIL full_beat%0d got=%h want=%h", i, obs_pkt[i], exp_pkt[i]); end
        end
        checks++; if (o_Vregs_output_addr0 !== 5'd3) begin errs++; $display("FAIL full_start_ignored got=%0d want=3", o_Vregs_output_addr0); end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errs++; $display("FAIL full_after_done got done=%b busy=%b want 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_sew16_tail;
        build_expect(5, 6, 5, 1, 1);
        start_seq(5, 6, 5, 1, 1);
        collect(0, -1, -1, 1'b0);
        checks++; if (n_xfer != 3) begin errs++; $display("FAIL sew16_xfers got=%0d want=3", n_xfer); end
        checks++; if (exp_pkt[2][6:3] !== 4'h3) begin errs++; $display("FAIL sew16_model_tail got=%h want=3", exp_pkt[2][6:3]); end
        for (int i = 0; i < 3 && i < n_xfer; i++) begin
            checks++;
            if (obs_pkt[i] !== exp_pkt[i]) begin errs++; $display("FAIL sew16_beat%0d got=%h want=%h", i, obs_pkt[i], exp_pkt[i]); end
        end
        checks++; if (done_k != 6) begin errs++; $display("FAIL sew16_done_cycle got=%0d want=6", done_k); end
    endtask

    task automatic test_masked_clamp;
        rf[0] = {$urandom, $urandom, $urandom, $urandom};
        rf[0][3:0] = 4'b0101;
        build_expect(9, 10, 9, 2, 0);
        start_seq(9, 10, 9, 2, 0);
        collect(0, -1, -1, 1'b0);
        checks++; if (n_xfer != 4) begin errs++; $display("FAIL mask_xfers got=%0d want=4", n_xfer); end
        for (int i = 0; i < 4 && i < n_xfer; i++) begin
            checks++;
            if (obs_pkt[i][6:3] !== ((i % 2 == 0) ? 4'hF : 4'h0)) begin
                errs++; $display("FAIL mask_ben%0d got=%h want=%h", i, obs_pkt[i][6:3], (i % 2 == 0) ? 4'hF : 4'h0);
            end
            checks++;
            if (obs_pkt[i] !== exp_pkt[i]) begin errs++; $display("FAIL mask_beat%0d got=%h want=%h", i, obs_pkt[i], exp_pkt[i]); end
        end
    endtask

    task automatic test_backpressure;
        build_expect(12, 13, 16, 0, 1);
        start_seq(12, 13, 16, 0, 1);
        collect(1, -1, -1, 1'b0);
        checks++; if (hold_viol != 0) begin errs++; $display("FAIL bp_hold got=%0d changes want=0", hold_viol); end
        checks++; if (n_xfer != 4) begin errs++; $display("FAIL bp_xfers got=%0d want=4", n_xfer); end
        for (int i = 0; i < 4 && i < n_xfer; i++) begin
            checks++;
            if (obs_pkt[i] !== exp_pkt[i]) begin errs++; $display("FAIL bp_beat%0d got=%h want=%h", i, obs_pkt[i], exp_pkt[i]); end
        end
        checks++; if (done_k < 0) begin errs++; $display("FAIL bp_done got=timeout want=pulse"); end
    endtask

    task automatic test_vl_zero;
        start_seq(2, 4, 0, 0, 1);
        collect(0, -1, -1, 1'b0);
        checks++; if (first_valid_k != -1) begin errs++; $display("FAIL vl0_valid got=cycle%0d want=none", first_valid_k); end
        checks++; if (done_k != 2) begin errs++; $display("FAIL vl0_done_cycle got=%0d want=2", done_k); end
    endtask

    task automatic test_snapshot_reset;
        int dones;
        build_expect(17, 18, 16, 0, 1);
        start_seq(17, 18, 16, 0, 1);
        collect(0, -1, 17, 1'b0);
        checks++; if (n_xfer != 4) begin errs++; $display("FAIL snap_xfers got=%0d want=4", n_xfer); end
        for (int i = 2; i < 4 && i < n_xfer; i++) begin
            checks++;
            if (obs_pkt[i][70:39] !== exp_pkt[i][70:39]) begin
                errs++; $display("FAIL snap_op_a%0d got=%h want=%h", i, obs_pkt[i][70:39], exp_pkt[i][70:39]);
            end
        end
        start_seq(20, 21, 16, 0, 1);
        collect(0, 2, -1, 1'b0);
        checks++; if (!aborted) begin errs++; $display("FAIL rst_mid_reach got=no_beat2 want=beat2"); end
        @(negedge i_clk);
        i_rst = 1'b0;
        checks++; if (o_busy !== 1'b0 || o_op_valid !== 1'b0) begin
            errs++; $display("FAIL rst_mid_state got busy=%b valid=%b want 0/0", o_busy, o_op_valid);
        end
        dones = 0;
        repeat (8) begin @(negedge i_clk); if (o_done) dones++; end
        checks++; if (dones != 0) begin errs++; $display("FAIL rst_mid_done got=%0d pulses want=0", dones); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            int vs1, vs2, vl, sew, vm;
            vs1 = $urandom_range(0, 31); vs2 = $urandom_range(0, 31);
            vl = $urandom_range(0, 31); sew = $urandom_range(0, 3); vm = $urandom_range(0, 1);
            rf[vs1] = {$urandom, $urandom, $urandom, $urandom};
            rf[vs2] = {$urandom, $urandom, $urandom, $urandom};
            rf[0] = {$urandom, $urandom, $urandom, $urandom};
            build_expect(vs1, vs2, vl, sew, vm);
            start_seq(vs1, vs2, vl, sew, vm);
            collect(2, -1, -1, 1'b0);
            checks++; if (done_k < 0) begin errs++; $display("FAIL rnd%0d_done got=timeout want=pulse", it); end
            checks++; if (n_xfer != exp_cnt) begin errs++; $display("FAIL rnd%0d_xfers got=%0d want=%0d", it, n_xfer, exp_cnt); end
            checks++; if (hold_viol != 0) begin errs++; $display("FAIL rnd%0d_hold got=%0d want=0", it, hold_viol); end
            for (int i = 0; i < exp_cnt && i < n_xfer; i++) begin
                checks++;
                if (obs_pkt[i] !== exp_pkt[i]) begin errs++; $display("FAIL rnd%0d_beat%0d got=%h want=%h", it, i, obs_pkt[i], exp_pkt[i]); end
            end
        end
    endtask

    initial begin
        errs = 0; checks = 0;
        i_rst = 1'b1; i_start = 1'b0; i_op_ready = 1'b1;
        i_vs1_addr = '0; i_vs2_addr = '0; i_vl = '0; i_sew = '0; i_vm = 1'b1;
        for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom, $urandom, $urandom};
        test_reset;
        test_full_unmasked;
        test_sew16_tail;
        test_masked_clamp;
        test_backpressure;
        test_vl_zero;
        test_snapshot_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
